// File: rtl/gpmc_async_target.sv
// GPMC asynchronous-mode target: oversamples the host pins in the fabric
// clock domain and turns each host read/write strobe into one request and
// response transaction on the internal register bus.
module gpmc_async_target #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    CS_COUNT    = 8,
    parameter int                    MUXED       = 1,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    TIMEOUT     = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = 16'hDEAD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CS_COUNT-1:0]           gpmc_cs_n,
    input  logic                          gpmc_adv_n,
    input  logic                          gpmc_oe_n,
    input  logic                          gpmc_we_n,
    input  logic [DATA_WIDTH/8-1:0]       gpmc_be_n,
    input  logic [ADDR_WIDTH-1:0]         gpmc_addr,
    input  logic [DATA_WIDTH-1:0]         gpmc_data_i,
    output logic [DATA_WIDTH-1:0]         gpmc_data_o,
    output logic                          gpmc_data_oe,
    output logic                          gpmc_wait_n,
    output logic                          bus_req_valid,
    input  logic                          bus_req_ready,
    output logic                          bus_req_write,
    output logic [$clog2(CS_COUNT)-1:0]   bus_req_cs,
    output logic [ADDR_WIDTH-1:0]         bus_req_addr,
    output logic [DATA_WIDTH-1:0]         bus_req_wdata,
    output logic [DATA_WIDTH/8-1:0]       bus_req_be,
    input  logic                          bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0]         bus_rsp_rdata,
    output logic                          err_timeout,
    output logic                          err_multi_cs
);

    localparam int BW  = DATA_WIDTH / 8;
    localparam int CSW = $clog2(CS_COUNT);
    localparam int TW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int SW  = CS_COUNT + 3 + BW + ADDR_WIDTH + DATA_WIDTH;
    // Idle pin image: all strobes and selects deasserted, address/data zero.
    localparam logic [SW-1:0] PINS_IDLE = {{(CS_COUNT + 3 + BW){1'b1}},
                                           {(ADDR_WIDTH + DATA_WIDTH){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACTIVE,
        S_REQ,
        S_RSP,
        S_DRIVE,
        S_DRAIN
    } state_t;

    logic [SW-1:0]         sync_q [SYNC_STAGES];
    logic [SW-1:0]         sync_d [SYNC_STAGES];
    logic [2:0]            edge_q, edge_d;

    logic [CS_COUNT-1:0]   s_cs_n;
    logic                  s_adv_n, s_oe_n, s_we_n;
    logic [BW-1:0]         s_be_n;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_data;

    logic                  adv_rise, oe_fall, oe_rise, we_rise;
    logic                  cs_hit, cs_multi;
    logic [CSW-1:0]        cs_first;
    logic [ADDR_WIDTH-1:0] muxed_addr;

    state_t                state_q, state_d;
    logic [CSW-1:0]        cs_idx_q, cs_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]         be_q, be_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  drain_req_q, drain_req_d;
    logic                  err_tmo_q, err_tmo_d;
    logic                  err_multi_q, err_multi_d;

    // Synchroniser chain: every pin travels together so a sample is coherent.
    always_comb begin
        sync_d[0] = {gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n,
                     gpmc_be_n, gpmc_addr, gpmc_data_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser registers, forced to the idle pin image on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PINS_IDLE;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign {s_cs_n, s_adv_n, s_oe_n, s_we_n, s_be_n, s_addr, s_data} = sync_q[SYNC_STAGES-1];
    assign edge_d   = {s_adv_n, s_oe_n, s_we_n};
    assign adv_rise =  s_adv_n & ~edge_q[2];
    assign oe_fall  = ~s_oe_n  &  edge_q[1];
    assign oe_rise  =  s_oe_n  & ~edge_q[1];
    assign we_rise  =  s_we_n  & ~edge_q[0];

    // Previous-sample register for strobe edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= 3'b111;
        end else begin
            edge_q <= edge_d;
        end
    end

    // Chip-select decode: lowest asserted index wins, flag more than one.
    always_comb begin
        cs_hit   = 1'b0;
        cs_multi = 1'b0;
        cs_first = '0;
        for (int i = 0; i < CS_COUNT; i++) begin
            if (!s_cs_n[i]) begin
                if (cs_hit) begin
                    cs_multi = 1'b1;
                end else begin
                    cs_first = CSW'(i);
                end
                cs_hit = 1'b1;
            end
        end
    end

    // Muxed address: upper bits from the address pins, low bits from AD.
    always_comb begin
        muxed_addr                 = s_addr;
        muxed_addr[DATA_WIDTH-1:0] = s_data;
    end

    // Access sequencer: next state and the per-access register updates.
    always_comb begin
        state_d     = state_q;
        cs_idx_d    = cs_idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        tmo_d       = tmo_q;
        drain_req_d = drain_req_q;
        err_tmo_d   = 1'b0;
        err_multi_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs_hit) begin
                    cs_idx_d    = cs_first;
                    err_multi_d = cs_multi;
                    if (MUXED != 0) begin
                        state_d = S_ADDR;
                    end else begin
                        addr_d  = s_addr;
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ADDR: begin
                if (!cs_hit) begin
                    state_d = S_IDLE;
                end else if (adv_rise) begin
                    addr_d  = muxed_addr;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!cs_hit) begin
                    state_d = S_IDLE;
                end else if (oe_fall) begin
                    write_d = 1'b0;
                    state_d = S_REQ;
                end else if (we_rise) begin
                    write_d = 1'b1;
                    wdata_d = s_data;
                    be_d    = ~s_be_n;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    tmo_d       = TW'(TIMEOUT);
                    drain_req_d = 1'b0;
                    state_d     = cs_hit ? S_RSP : S_DRAIN;
                end else if (!cs_hit) begin
                    drain_req_d = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
            S_RSP: begin
                if (!cs_hit) begin
                    drain_req_d = 1'b0;
                    state_d     = bus_rsp_valid ? S_IDLE : S_DRAIN;
                end else if (bus_rsp_valid || tmo_q == '0) begin
                    err_tmo_d = ~bus_rsp_valid;
                    if (write_q) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = S_ACTIVE;
                    end else begin
                        rdata_d = bus_rsp_valid ? bus_rsp_rdata : ERR_DATA;
                        state_d = S_DRIVE;
                    end
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            S_DRIVE: begin
                if (!cs_hit) begin
                    state_d = S_IDLE;
                end else if (oe_rise) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_ACTIVE;
                end
            end
            S_DRAIN: begin
                // Abandoned access: finish the bus handshake silently.
                if (drain_req_q) begin
                    if (bus_req_ready) begin
                        drain_req_d = 1'b0;
                        tmo_d       = TW'(TIMEOUT);
                    end
                end else if (bus_rsp_valid || tmo_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and access registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cs_idx_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            tmo_q       <= '0;
            drain_req_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_idx_q    <= cs_idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            tmo_q       <= tmo_d;
            drain_req_q <= drain_req_d;
            err_tmo_q   <= err_tmo_d;
            err_multi_q <= err_multi_d;
        end
    end

    assign bus_req_valid = (state_q == S_REQ) || (state_q == S_DRAIN && drain_req_q);
    assign bus_req_write = write_q;
    assign bus_req_cs    = cs_idx_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_wdata = wdata_q;
    assign bus_req_be    = be_q;
    assign gpmc_wait_n   = !(state_q == S_REQ || state_q == S_RSP || state_q == S_DRAIN);
    assign gpmc_data_oe  = (state_q == S_DRIVE);
    assign gpmc_data_o   = rdata_q;
    assign err_timeout   = err_tmo_q;
    assign err_multi_cs  = err_multi_q;

endmodule
